uart_mem_ctrl: RTL and testbench



---
 rtl/uart_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_mem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - UART receive-to-memory store with full-memory serial playback
module uart_mem_ctrl #(
    parameter int CLKS_PER_BIT = 21,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int ADDR_W       = 12,
    parameter int ERR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rx_Serial,
    input  logic              mem2uart,
    output logic              Tx_Serial,
    output logic              recv_done,
    output logic              send_done,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   rx_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // NEXT supplies the final stop-bit clock, so STOP ends one clock early
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_STORE} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_NEXT} tx_state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];

    rx_state_t            rx_state, rx_next;
    logic                 rx_meta, rx_sync;
    logic [CNT_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_err, rx_half, rx_full, rx_write;

    tx_state_t            tx_state, tx_next;
    logic [CNT_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]     tx_bit;
    logic [ADDR_W-1:0]    tx_addr;
    logic [DATA_BITS-1:0] tx_word;
    logic                 tx_full, tx_last_addr;

    assign rx_half      = (rx_cnt == HALF_LAST);
    assign rx_full      = (rx_cnt == BIT_LAST);
    assign rx_write     = (rx_state == RX_STORE) && !rx_err && !recv_done && !rx_count[ADDR_W];
    assign tx_full      = (tx_cnt == BIT_LAST);
    assign tx_last_addr = (tx_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            rx_meta  <= Rx_Serial;
            rx_sync  <= rx_meta;
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (!rx_sync) rx_next = RX_START;
            RX_START:  if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_full && rx_bit == DATA_LAST)
                           rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_full) rx_next = RX_STOP;
            RX_STOP:   if (rx_full) rx_next = RX_STORE;
            RX_STORE:  rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_err    <= 1'b0;
            rx_count  <= '0;
            err_count <= '0;
            recv_done <= 1'b0;
        end else begin
            rx_cnt <= (rx_state == RX_IDLE || rx_next != rx_state || rx_full) ? '0 : rx_cnt + 1'b1;
            if (rx_state == RX_START) begin
                rx_bit <= '0;
                rx_err <= 1'b0;
            end
            if (rx_state == RX_DATA && rx_full) begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == RX_PARITY && rx_full && ((^rx_shift ^ rx_sync) != PAR_ODD))
                rx_err <= 1'b1;
            if (rx_state == RX_STOP && rx_full && !rx_sync)
                rx_err <= 1'b1;
            if (rx_write)
                rx_count <= rx_count + 1'b1;
            if (rx_state == RX_STORE && rx_err && err_count != {ERR_W{1'b1}})
                err_count <= err_count + 1'b1;
            if (rx_count[ADDR_W])
                recv_done <= 1'b1;
        end
    end

    // Memory is deliberately left out of reset; tx_word trails tx_addr by one clock
    always_ff @(posedge clk) begin
        if (rx_write)
            mem[rx_count[ADDR_W-1:0]] <= rx_shift;
        tx_word <= mem[tx_addr];
    end

    always_comb begin
        tx_next   = tx_state;
        Tx_Serial = 1'b1;
        case (tx_state)
            TX_IDLE:   if (mem2uart && recv_done && !send_done) tx_next = TX_START;
            TX_START: begin
                Tx_Serial = 1'b0;
                if (tx_full) tx_next = TX_DATA;
            end
            TX_DATA: begin
                Tx_Serial = tx_word[tx_bit];
                if (tx_full && tx_bit == DATA_LAST)
                    tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                Tx_Serial = ^tx_word ^ PAR_ODD;
                if (tx_full) tx_next = TX_STOP;
            end
            TX_STOP:   if (tx_cnt == STOP_LAST) tx_next = TX_NEXT;
            TX_NEXT:   tx_next = tx_last_addr ? TX_IDLE : TX_START;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_addr   <= '0;
            send_done <= 1'b0;
        end else begin
            tx_cnt <= (tx_state == TX_IDLE || tx_next != tx_state || (tx_full && tx_state != TX_STOP))
                      ? '0 : tx_cnt + 1'b1;
            if (tx_state == TX_START)
                tx_bit <= '0;
            if (tx_state == TX_DATA && tx_full)
                tx_bit <= tx_bit + 1'b1;
            if (tx_state == TX_NEXT) begin
                tx_addr <= tx_addr + 1'b1;
                if (tx_last_addr)
                    send_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb/tb_uart_mem_ctrl.sv - scoreboard bench for uart_mem_ctrl fill, playback, errors and reset
module tb_uart_mem_ctrl;
    localparam int CPB = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_p, rx_line, rx_line_p, mem2uart, mem2uart_p;
    logic       tx_serial, recv_done, send_done;
    logic [7:0] err_count;
    logic [2:0] rx_count;
    logic       tx_serial_p, recv_done_p, send_done_p;
    logic [7:0] err_count_p;
    logic [2:0] rx_count_p;

    uart_mem_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .ADDR_W(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .Rx_Serial(rx_line), .mem2uart(mem2uart),
        .Tx_Serial(tx_serial), .recv_done(recv_done), .send_done(send_done),
        .err_count(err_count), .rx_count(rx_count));

    uart_mem_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                    .ADDR_W(2), .ERR_W(8)) dut_p (
        .clk(clk), .rst(rst_p), .Rx_Serial(rx_line_p), .mem2uart(mem2uart_p),
        .Tx_Serial(tx_serial_p), .recv_done(recv_done_p), .send_done(send_done_p),
        .err_count(err_count_p), .rx_count(rx_count_p));

    typedef struct {logic [7:0] data; bit first;} tx_exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tx_gen = 0;
    bit          mon_en = 1'b0;
    bit          done_p = 1'b0;
    tx_exp_t     exp_tx[$];
    logic [10:0] exp_rx[$];
    logic [10:0] exp_rx_p[$];
    logic [10:0] last_rx, last_rx_p;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] f8(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    function automatic logic [15:0] f7p(input logic [6:0] d, input logic par);
        return {5'b0, 2'b11, par, d, 1'b0};
    endfunction

    task automatic send(input bit port, input logic [15:0] fr, input int nbits, input int last_len);
        for (int i = 0; i < nbits; i++) begin
            if (port) rx_line_p = fr[i];
            else      rx_line   = fr[i];
            repeat ((i == nbits - 1) ? last_len : CPB) @(negedge clk);
        end
        if (port) rx_line_p = 1'b1;
        else      rx_line   = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
        exp_tx.push_back('{a, 1'b1});
        exp_tx.push_back('{b, 1'b0});
        exp_tx.push_back('{c, 1'b0});
        exp_tx.push_back('{d, 1'b0});
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d);
        logic [7:0] v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            exp_rx.push_back({3'(k + 1), 8'd0});
            send(1'b0, f8(v[k], 1'b1), 10, CPB);
        end
    endtask

    task automatic wait_recv_done(input string name);
        int n = 0;
        while (recv_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_send_done(input string name);
        int n = 0;
        while (send_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx"}, 32'(tx_serial), 32'd1);
        chk({tag, "_rx_count"}, 32'(rx_count), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_recv_done"}, 32'(recv_done), 32'd0);
        chk({tag, "_send_done"}, 32'(send_done), 32'd0);
    endtask

    // RX scoreboard: every change of {rx_count, err_count} must match the next expected event
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ({rx_count, err_count} !== last_rx) begin
                    if (exp_rx.size() == 0) chk("rx_unexpected_event", 32'({rx_count, err_count}), 32'hFFFF_FFFF);
                    else chk("rx_event", 32'({rx_count, err_count}), 32'(exp_rx.pop_front()));
                    last_rx = {rx_count, err_count};
                end
                if ({rx_count_p, err_count_p} !== last_rx_p) begin
                    if (exp_rx_p.size() == 0) chk("rxp_unexpected_event", 32'({rx_count_p, err_count_p}), 32'hFFFF_FFFF);
                    else chk("rxp_event", 32'({rx_count_p, err_count_p}), 32'(exp_rx_p.pop_front()));
                    last_rx_p = {rx_count_p, err_count_p};
                end
            end
        end
    end

    // TX scoreboard: decode each frame on the serial line and compare against the queue
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       ok_start, ok_stop;
        int         g, t0, last_start;
        tx_exp_t    e;
        prev = 1'b1;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx_serial) begin
                g  = tx_gen;
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                ok_start = !tx_serial;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = tx_serial;
                end
                repeat (CPB) @(negedge clk);
                ok_stop = tx_serial;
                if (g == tx_gen) begin
                    if (exp_tx.size() == 0) begin
                        chk("tx_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx_byte", 32'(b), 32'(e.data));
                        chk("tx_start_bit", 32'(ok_start), 32'd1);
                        chk("tx_stop_bit", 32'(ok_stop), 32'd1);
                        if (!e.first) chk("tx_frame_spacing", 32'(t0 - last_start), 32'(10 * CPB));
                    end
                end
                last_start = t0;
                prev = 1'b1;
            end else begin
                prev = tx_serial;
            end
        end
    end

    initial begin
        int lows, n;
        rst = 1'b1; rst_p = 1'b1; rx_line = 1'b1; rx_line_p = 1'b1;
        mem2uart = 1'b0; mem2uart_p = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_p = 1'b0;
        chk_reset_state("reset");
        last_rx = {rx_count, err_count};
        last_rx_p = {rx_count_p, err_count_p};
        mon_en = 1'b1;

        fork
            begin
                exp_rx_p.push_back({3'd1, 8'd0});
                send(1'b1, f7p(7'h55, 1'b0), 11, CPB);
                exp_rx_p.push_back({3'd1, 8'd1});
                send(1'b1, f7p(7'h55, 1'b1), 11, CPB);
                exp_rx_p.push_back({3'd2, 8'd1});
                send(1'b1, f7p(7'h07, 1'b1), 11, CPB);
                chk("parity_dut_tx_idle", 32'(tx_serial_p), 32'd1);
                done_p = 1'b1;
            end
        join_none

        // Trigger held high from the start: playback must wait for recv_done
        mem2uart = 1'b1;
        exp_rx.push_back({3'd1, 8'd0}); send(1'b0, f8(8'h00, 1'b1), 10, CPB);
        exp_rx.push_back({3'd2, 8'd0}); send(1'b0, f8(8'hFF, 1'b1), 10, CPB);
        exp_rx.push_back({3'd3, 8'd0}); send(1'b0, f8(8'hA5, 1'b1), 10, CPB);
        chk("tx_idle_before_recv_done", 32'(tx_serial), 32'd1);
        push_tx(8'h00, 8'hFF, 8'hA5, 8'h3C);
        exp_rx.push_back({3'd4, 8'd0});
        fork
            send(1'b0, f8(8'h3C, 1'b1), 10, CPB);
            begin
                n = 0;
                while (rx_count !== 3'd4 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                chk("fill_a_timeout", 32'(n < 1000), 32'd1);
                chk("recv_done_lags_count", 32'(recv_done), 32'd0);
                @(negedge clk);
                chk("recv_done_rise", 32'(recv_done), 32'd1);
                chk("tx_idle_at_recv_done", 32'(tx_serial), 32'd1);
                @(negedge clk);
                chk("tx_autoplay_start", 32'(tx_serial), 32'd0);
            end
        join

        // Framing error and glitch while full: errors still counted, nothing stored
        exp_rx.push_back({3'd4, 8'd1});
        send(1'b0, f8(8'h5A, 1'b0), 10, 14);
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_rx_count", 32'(rx_count), 32'd4);
        chk("glitch_err_count", 32'(err_count), 32'd1);

        wait_send_done("send_done_a_timeout");
        chk("tx_idle_after_playback", 32'(tx_serial), 32'd1);
        mem2uart = 1'b0;
        @(negedge clk);
        mem2uart = 1'b1;
        @(negedge clk);
        mem2uart = 1'b0;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!tx_serial) lows++;
        end
        chk("no_second_playback", 32'(lows), 32'd0);
        chk("send_done_sticky", 32'(send_done), 32'd1);

        rst = 1'b1;
        exp_rx.push_back({3'd0, 8'd0});
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset_b");
        fill(8'h11, 8'h22, 8'h33, 8'h44);
        wait_recv_done("fill_b_timeout");
        push_tx(8'h11, 8'h22, 8'h33, 8'h44);
        mem2uart = 1'b1;
        chk("tx_idle_pre_trigger", 32'(tx_serial), 32'd1);
        @(negedge clk);
        chk("tx_start_latency", 32'(tx_serial), 32'd0);
        mem2uart = 1'b0;
        repeat (100) @(negedge clk);

        // Reset lands mid TX frame and mid RX frame
        fork
            send(1'b0, f8(8'hFF, 1'b1), 10, CPB);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                tx_gen++;
                exp_tx.delete();
                exp_rx.push_back({3'd0, 8'd0});
                @(negedge clk);
                rst = 1'b0;
                chk_reset_state("mid_reset");
            end
        join

        fill(8'h5A, 8'h0F, 8'hF0, 8'h81);
        wait_recv_done("fill_c_timeout");
        push_tx(8'h5A, 8'h0F, 8'hF0, 8'h81);
        mem2uart = 1'b1;
        @(negedge clk);
        chk("tx_start_latency_c", 32'(tx_serial), 32'd0);
        mem2uart = 1'b0;
        wait_send_done("send_done_c_timeout");
        repeat (50) @(negedge clk);

        n = 0;
        while (!done_p && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("parity_seq_timeout", 32'(done_p), 32'd1);
        chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        chk("rxp_queue_drained", 32'(exp_rx_p.size()), 32'd0);
        chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
